// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, instruction field widths and the
// fetch sequencer state encoding.
package mips_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned TARGET_W = 26;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    StBoot   = 2'd0,
    StRun    = 2'd1,
    StBubble = 2'd2,
    StHalt   = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the word-indexed PC, drives the instruction
// memory address and registers the fetched word into the IF/ID register.
// Optional feature: define FETCH_JUMP_PREDECODE_EN to follow j instructions
// locally instead of waiting for a downstream redirect.
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] if_instr,
  output logic [INSTR_W-1:0] if_pc,
  output logic               if_valid,
  output logic               halted
);

  localparam logic [INSTR_W-1:0] DepthW   = INSTR_W'(MEM_DEPTH);
  localparam logic [INSTR_W-1:0] ResetPcW = INSTR_W'(RESET_PC);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [INSTR_W-1:0] if_pc_q, if_pc_d;
  logic               if_valid_q, if_valid_d;

`ifdef FETCH_JUMP_PREDECODE_EN
  logic [INSTR_W-1:0] jump_tgt;
  assign jump_tgt = {pc_q[INSTR_W-1:TARGET_W], imem_instr[TARGET_W-1:0]};
`endif

  // Next-state: priority redirect > stall > local jump > sequential fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;

    if (state_q == StBoot) begin
      // Boot spends one cycle without fetching; redirects are not accepted yet.
      if (!stall) state_d = StRun;
    end else if (redirect_valid) begin
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
      state_d    = (redirect_pc >= DepthW) ? StHalt : StBubble;
    end else if (!stall) begin
      if (state_q == StHalt) begin
        if_valid_d = 1'b0;
      end else if (pc_q >= DepthW) begin
        // Out-of-range fetch: freeze the PC and stop issuing.
        state_d    = StHalt;
        if_valid_d = 1'b0;
      end else begin
        if_instr_d = imem_instr;
        if_pc_d    = pc_q;
        if_valid_d = 1'b1;
        pc_d       = pc_q + 32'd1;
        state_d    = StRun;
`ifdef FETCH_JUMP_PREDECODE_EN
        if (state_q == StRun && imem_instr[INSTR_W-1:TARGET_W] == OP_J) begin
          pc_d    = jump_tgt;
          state_d = (jump_tgt >= DepthW) ? StHalt : StBubble;
        end
`endif
      end
    end
  end

  // State, PC and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StBoot;
      pc_q       <= ResetPcW;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

  // Outputs are direct views of the registers.
  always_comb begin
    imem_addr = pc_q;
    if_instr  = if_instr_q;
    if_pc     = if_pc_q;
    if_valid  = if_valid_q;
    halted    = (state_q == StHalt);
  end

endmodule
